// File: rtl/treadmill_pkg.sv
// Shared types and constants for the treadmill motor drive.
// Holds the drive state encoding, datapath widths and the BCD digit adjust step.
package treadmill_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEL  = 3'd1,
        DECEL  = 3'd2,
        CRUISE = 3'd3,
        STOP   = 3'd4
    } drive_state_t;

    localparam int SPEED_W       = 8;
    localparam int BCD_W         = 4;
    localparam int MAX_SPEED_DEF = 199;

    // One double-dabble correction: every digit of 5 or more gets +3 before the shift.
    function automatic logic [3*BCD_W-1:0] bcd_adjust(input logic [3*BCD_W-1:0] d);
        logic [3*BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < 3; i++) begin
            if (d[i*BCD_W +: BCD_W] >= 4'd5) begin
                r[i*BCD_W +: BCD_W] = d[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/treadmill_drive_speed_bcd.sv
// speed_bcd: 8-bit binary to three BCD digits, one shift per clock.
// start is taken only while idle; bcd_o changes all digits at once when done_o pulses.
module speed_bcd
    import treadmill_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [SPEED_W-1:0]   bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [3*BCD_W-1:0]   bcd_o
);

    localparam int DIG_W = 3 * BCD_W;
    localparam int CNT_W = $clog2(SPEED_W);

    logic [SPEED_W-1:0] bin_q, bin_d;
    logic [DIG_W-1:0]   work_q, work_d, bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;

    always_comb begin
        adj    = bcd_adjust(work_q);
        bin_d  = bin_q;
        work_d = work_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            work_d = DIG_W'({adj, bin_q[SPEED_W-1]});
            bin_d  = {bin_q[SPEED_W-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SPEED_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                bcd_d  = work_d;
            end
        end else if (start_i) begin
            bin_d  = bin_i;
            work_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q  <= '0;
            work_q <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            work_q <= work_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/treadmill_drive.sv
// Treadmill motor drive: clamps the target speed, ramps actual speed toward it, drives PWM and BCD display.
// Define DRIVE_ESTOP_EN to honour estop (fast ramp-down with restart interlock); otherwise estop is ignored.
module treadmill_drive
    import treadmill_pkg::*;
#(
    parameter int MAX_SPEED  = MAX_SPEED_DEF,
    parameter int RAMP_TICKS = 5_000_000,
    parameter int PWM_PERIOD = 200
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic               estop,
    output logic               pwm,
    output logic [SPEED_W-1:0] actual_speed,
    output logic [BCD_W-1:0]   act1,
    output logic [BCD_W-1:0]   act2,
    output logic [BCD_W-1:0]   act3,
    output logic               at_target,
    output logic               ramping
);

    localparam int                 TICK_W    = $clog2(RAMP_TICKS);
    localparam int                 PWM_W     = $clog2(PWM_PERIOD);
    localparam logic [SPEED_W-1:0] MAX_S     = SPEED_W'(MAX_SPEED);
    localparam logic [TICK_W-1:0]  RAMP_LAST = TICK_W'(RAMP_TICKS - 1);
    localparam logic [PWM_W-1:0]   PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
`ifdef DRIVE_ESTOP_EN
    localparam logic [TICK_W-1:0]  STOP_LAST = TICK_W'(RAMP_TICKS / 4 - 1);
`endif

    drive_state_t       state_q, state_d;
    logic [SPEED_W-1:0] target_q, target_d, actual_q, actual_d, stepped;
    logic [SPEED_W-1:0] duty_q, duty_d, sent_q, sent_d;
    logic [TICK_W-1:0]  tick_q, tick_d, tick_last;
    logic [PWM_W-1:0]   pcnt_q, pcnt_d;
    logic               pwm_q, pwm_d, at_target_q, ramping_q, in_ramp;
    logic               bcd_start, bcd_busy, unused_bcd_done;
    logic [3*BCD_W-1:0] bcd_val;

    assign in_ramp = (state_q == ACCEL) || (state_q == DECEL) || (state_q == STOP);

    always_comb begin
        target_d  = (speed > MAX_S) ? MAX_S : speed;
        state_d   = state_q;
        actual_d  = actual_q;
        stepped   = actual_q;
        tick_last = RAMP_LAST;
        case (state_q)
            IDLE: begin
                if (target_q != '0) state_d = ACCEL;
            end
            CRUISE: begin
                if (target_q > actual_q)      state_d = ACCEL;
                else if (target_q < actual_q) state_d = DECEL;
            end
            ACCEL, DECEL: begin
                // Direction is chosen afresh at every tick so a reversal costs no extra interval.
                if (tick_q == RAMP_LAST) begin
                    if (target_q > actual_q)      stepped = actual_q + 8'd1;
                    else if (target_q < actual_q) stepped = actual_q - 8'd1;
                    actual_d = stepped;
                    if (stepped == target_q)     state_d = (stepped == '0) ? IDLE : CRUISE;
                    else if (stepped < target_q) state_d = ACCEL;
                    else                         state_d = DECEL;
                end
            end
`ifdef DRIVE_ESTOP_EN
            STOP: begin
                tick_last = STOP_LAST;
                if (tick_q == STOP_LAST && actual_q != '0) actual_d = actual_q - 8'd1;
                if (!estop && actual_q == '0 && target_q == '0) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef DRIVE_ESTOP_EN
        if (estop) state_d = STOP;
`endif
        if (state_d != state_q || !in_ramp) tick_d = '0;
        else if (tick_q == tick_last)       tick_d = '0;
        else                                tick_d = tick_q + TICK_W'(1);
    end

`ifndef DRIVE_ESTOP_EN
    logic unused_estop;
    assign unused_estop = estop;
`endif

    // Duty is sampled only at count 0 so a speed change never splits a PWM period.
    always_comb begin
        pcnt_d = (pcnt_q == PWM_LAST) ? '0 : pcnt_q + PWM_W'(1);
        duty_d = (pcnt_q == '0) ? actual_q : duty_q;
        pwm_d  = 32'(pcnt_q) < 32'(duty_d);
    end

    assign bcd_start = !bcd_busy && (actual_q != sent_q);
    assign sent_d    = bcd_start ? actual_q : sent_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            actual_q    <= '0;
            tick_q      <= '0;
            pcnt_q      <= '0;
            duty_q      <= '0;
            pwm_q       <= 1'b0;
            sent_q      <= '0;
            at_target_q <= 1'b1;
            ramping_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            actual_q    <= actual_d;
            tick_q      <= tick_d;
            pcnt_q      <= pcnt_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            sent_q      <= sent_d;
            at_target_q <= (actual_q == target_q);
            ramping_q   <= in_ramp;
        end
    end

    speed_bcd u_bcd (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset),
        .start_i (bcd_start),
        .bin_i   (actual_q),
        .busy_o  (bcd_busy),
        .done_o  (unused_bcd_done),
        .bcd_o   (bcd_val)
    );

    assign pwm          = pwm_q;
    assign actual_speed = actual_q;
    assign act1         = bcd_val[3*BCD_W-1:2*BCD_W];
    assign act2         = bcd_val[2*BCD_W-1:BCD_W];
    assign act3         = bcd_val[BCD_W-1:0];
    assign at_target    = at_target_q;
    assign ramping      = ramping_q;

endmodule

// File: tb/tb_treadmill_drive.sv
// Directed bench for treadmill_drive with RAMP_TICKS = 16 and PWM_PERIOD = 200.
module tb_treadmill_drive;

    logic       clk;
    logic       reset;
    logic [7:0] speed;
    logic       estop;
    logic       pwm;
    logic [7:0] actual_speed;
    logic [3:0] act1, act2, act3;
    logic       at_target;
    logic       ramping;

    int n_tests = 0;
    int n_fail  = 0;

    treadmill_drive #(
        .MAX_SPEED  (199),
        .RAMP_TICKS (16),
        .PWM_PERIOD (200)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .speed        (speed),
        .estop        (estop),
        .pwm          (pwm),
        .actual_speed (actual_speed),
        .act1         (act1),
        .act2         (act2),
        .act3         (act3),
        .at_target    (at_target),
        .ramping      (ramping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_actual(input string tag, input int v, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (actual_speed == 8'(v)) break;
            step(1);
        end
        chk(tag, actual_speed, v);
    endtask

    task automatic chk_digits(input string tag, input int d1, input int d2, input int d3);
        chk({tag, "_d1"}, act1, d1);
        chk({tag, "_d2"}, act2, d2);
        chk({tag, "_d3"}, act3, d3);
    endtask

    initial begin
        int  hi;
        bit  found;
        logic prev;
        logic [7:0] prev_act;

        reset = 1'b1;
        speed = 8'd0;
        estop = 1'b0;

        // Asynchronous reset: outputs settle before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_actual", actual_speed, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_at_target", at_target, 1);
        chk("rst_ramping", ramping, 0);
        chk_digits("rst_bcd", 0, 0, 0);
        step(3);
        reset = 1'b1;
        step(2);
        chk("idle_actual", actual_speed, 0);
        chk("idle_at_target", at_target, 1);

        // Scenario 1: ramp 0 -> 5, first step 18 cycles after speed applied
        speed = 8'd5;
        step(17);
        chk("s1_before_first", actual_speed, 0);
        step(1);
        chk("s1_first_step", actual_speed, 1);
        chk("s1_ramping", ramping, 1);
        for (int k = 2; k <= 5; k++) begin
            step(15);
            chk("s1_hold", actual_speed, k - 1);
            step(1);
            chk("s1_step", actual_speed, k);
        end
        chk("s1_at_target_lag", at_target, 0);
        step(1);
        chk("s1_at_target", at_target, 1);
        chk("s1_cruise", ramping, 0);

        // Scenario 3: decel toward 2, then reversal mid-ramp
        speed = 8'd2;
        step(17);
        chk("s3_hold5", actual_speed, 5);
        chk_digits("s1_bcd", 0, 0, 5);
        step(1);
        chk("s3_dec4", actual_speed, 4);
        step(16);
        chk("s3_dec3", actual_speed, 3);
        speed = 8'd6;
        step(15);
        chk("s3_hold3", actual_speed, 3);
        step(1);
        chk("s3_reverse", actual_speed, 4);
        step(32);
        chk("s3_reach6", actual_speed, 6);
        step(2);
        chk("s3_at_target", at_target, 1);

        // Scenario 5: PWM duty at 50, then 51 applied at count 100
        speed = 8'd50;
        wait_actual("s5_reach50", 50, 800);
        step(250);
        chk("s5_cruise", ramping, 0);
        found = 1'b0;
        prev  = pwm;
        for (int i = 0; i < 450; i++) begin
            step(1);
            if (pwm && !prev) begin
                found = 1'b1;
                break;
            end
            prev = pwm;
        end
        chk("s5_period_edge", found, 1);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (pwm) hi++;
            if (i == 82) speed = 8'd51;
            step(1);
        end
        chk("s5_duty50", hi, 50);
        chk("s5_actual51", actual_speed, 51);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (pwm) hi++;
            step(1);
        end
        chk("s5_duty51", hi, 51);

        // Scenario 6: BCD of 137 within 10 cycles
        speed = 8'd137;
        wait_actual("s6_reach137", 137, 1600);
        step(10);
        chk_digits("s6_bcd137", 1, 3, 7);

        // Scenario 2: clamp 250 -> 199, no overflow
        speed = 8'd250;
        step(993);
        chk("s2_at198", actual_speed, 198);
        step(1);
        chk("s2_at199", actual_speed, 199);
        step(200);
        chk("s2_hold199", actual_speed, 199);
        chk("s2_at_target", at_target, 1);
        chk("s2_cruise", ramping, 0);
        chk_digits("s2_bcd199", 1, 9, 9);

        speed = 8'd20;
        wait_actual("s4_reach20", 20, 3000);
        step(20);
        chk("s4_cruise20", ramping, 0);

`ifdef DRIVE_ESTOP_EN
        // Scenario 4: estop ramp-down and restart interlock
        estop = 1'b1;
        step(4);
        chk("s4_stop_hold", actual_speed, 20);
        step(1);
        chk("s4_stop_first", actual_speed, 19);
        step(4);
        chk("s4_stop_second", actual_speed, 18);
        step(72);
        chk("s4_stop_zero", actual_speed, 0);
        chk("s4_stop_ramping", ramping, 1);
        estop = 1'b0;
        step(50);
        chk("s4_interlock_actual", actual_speed, 0);
        chk("s4_interlock_ramping", ramping, 1);
        speed = 8'd0;
        step(3);
        chk("s4_back_idle", ramping, 0);
        speed = 8'd3;
        step(17);
        chk("s4_restart_hold", actual_speed, 0);
        chk("s4_restart_ramping", ramping, 1);
        step(1);
        chk("s4_restart_step", actual_speed, 1);
`else
        // estop has no effect in this build
        estop = 1'b1;
        step(40);
        chk("s4_estop_ignored", actual_speed, 20);
        chk("s4_estop_no_ramp", ramping, 0);
        estop = 1'b0;
        step(1);
`endif

        // Scenario 6b: reset asserted mid-conversion
        speed    = 8'd30;
        prev_act = actual_speed;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (actual_speed != prev_act) break;
        end
        chk("s6_changed", actual_speed != prev_act, 1);
        step(3);
        reset = 1'b0;
        #1;
        chk("s6_rst_actual", actual_speed, 0);
        chk("s6_rst_pwm", pwm, 0);
        chk("s6_rst_at_target", at_target, 1);
        chk("s6_rst_ramping", ramping, 0);
        chk_digits("s6_rst_bcd", 0, 0, 0);
        step(2);
        reset = 1'b1;
        step(5);
        chk("s6_post_rst_actual", actual_speed, 0);
        chk_digits("s6_post_rst_bcd", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
